// File: rtl/fpu_result_queue16_if.sv
// Handshake bundle between the FPU add/sub result producer, the result queue
// and its consumer. The queue connects through the slave modport.
interface fpu_result_queue16_if #(parameter int DEPTH = 4);
  logic                       in_valid;
  logic                       in_ready;
  logic [15:0]                in_result;
  logic [3:0]                 in_cc;
  logic                       out_valid;
  logic                       out_ready;
  logic [15:0]                out_result;
  logic [3:0]                 out_cc;
  logic [$clog2(DEPTH):0]     count;
  logic                       clear_sticky;
  logic [5:0]                 sticky;

  modport master (
    output in_valid, in_result, in_cc, out_ready, clear_sticky,
    input  in_ready, out_valid, out_result, out_cc, count, sticky
  );

  modport slave (
    input  in_valid, in_result, in_cc, out_ready, clear_sticky,
    output in_ready, out_valid, out_result, out_cc, count, sticky
  );
endinterface

// File: rtl/fpu_result_queue16.sv
// First-word-fall-through queue for fp16 add/sub results and condition codes.
// Define FPU_RESULT_STICKY_EN to build in the {NAN,INF,Z,C,N,V} sticky flags.
module fpu_result_queue16 #(
  parameter int DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset_L,
  fpu_result_queue16_if.slave  q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   res_mem [DEPTH];
  logic [3:0]    cc_mem  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  always_comb begin
    push     = q.in_valid && (count_q != FULL);
    pop      = (count_q != '0) && q.out_ready;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (reset_L && push) begin
      res_mem[wr_ptr_q] <= q.in_result;
      cc_mem[wr_ptr_q]  <= q.in_cc;
    end
  end

  assign q.in_ready   = (count_q != FULL);
  assign q.out_valid  = (count_q != '0);
  assign q.out_result = (count_q != '0) ? res_mem[rd_ptr_q] : 16'h0000;
  assign q.out_cc     = (count_q != '0) ? cc_mem[rd_ptr_q]  : 4'h0;
  assign q.count      = count_q;

`ifdef FPU_RESULT_STICKY_EN
  logic [5:0] sticky_q, sticky_d;
  logic [5:0] in_flags;
  logic       exp_max, frac_zero;

  always_comb begin
    exp_max   = (q.in_result[14:10] == 5'h1F);
    frac_zero = (q.in_result[9:0] == 10'h000);
    in_flags  = {exp_max && !frac_zero, exp_max && frac_zero, q.in_cc};
    // A push in the same cycle as a clear must survive the clear.
    sticky_d  = (q.clear_sticky ? 6'b0 : sticky_q) | (push ? in_flags : 6'b0);
  end

  always_ff @(posedge clock) begin
    if (!reset_L) sticky_q <= '0;
    else          sticky_q <= sticky_d;
  end

  assign q.sticky = sticky_q;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = q.clear_sticky;
  assign q.sticky = 6'b0;
`endif
endmodule

// File: tb/tb_fpu_result_queue16.sv
// Directed self-checking bench for fpu_result_queue16 with DEPTH=4.
module tb_fpu_result_queue16;
  logic clock = 1'b0;
  logic reset_L;
  int   errors = 0;
  int   checks = 0;

`ifdef FPU_RESULT_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  fpu_result_queue16_if #(.DEPTH(4)) bus ();

  fpu_result_queue16 #(.DEPTH(4)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .q       (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_stk;
    reset_L          = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_result    = 16'h0;
    bus.in_cc        = 4'h0;
    bus.out_ready    = 1'b0;
    bus.clear_sticky = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
    chk("rst_count", 16'(bus.count), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_result", bus.out_result, 16'h0);
    chk("rst_out_cc", 16'(bus.out_cc), 16'h0);
    chk("rst_sticky", 16'(bus.sticky), 16'h0);

    // single push, held while consumer stalls
    bus.in_valid = 1'b1; bus.in_result = 16'h3C00; bus.in_cc = 4'b0000;
    chk("push_same_cycle_invisible", 16'(bus.out_valid), 16'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("push1_out_valid", 16'(bus.out_valid), 16'd1);
    chk("push1_out_result", bus.out_result, 16'h3C00);
    chk("push1_count", 16'(bus.count), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_out_result", bus.out_result, 16'h3C00);
      chk("hold_count", 16'(bus.count), 16'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain1_count", 16'(bus.count), 16'd0);
    chk("drain1_out_result", bus.out_result, 16'h0);

    // overfill: 5 pushes into 4 entries
    for (int k = 1; k <= 5; k++) begin
      bus.in_valid = 1'b1; bus.in_result = 16'(k); bus.in_cc = 4'h0;
      tick();
      chk("fill_count", 16'(bus.count), (k < 4) ? 16'(k) : 16'd4);
      chk("fill_in_ready", 16'(bus.in_ready), (k < 4) ? 16'd1 : 16'd0);
    end
    // full: push attempt with a concurrent pop is still dropped
    bus.in_result = 16'h0009; bus.out_ready = 1'b1;
    chk("full_head", bus.out_result, 16'h0001);
    tick();
    bus.in_valid = 1'b0;
    chk("full_pushpop_count", 16'(bus.count), 16'd3);
    for (int k = 2; k <= 4; k++) begin
      chk("drain_order", bus.out_result, 16'(k));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("drained_count", 16'(bus.count), 16'd0);
    chk("drained_out_valid", 16'(bus.out_valid), 16'd0);

    // steady-state push+pop at count=2 across pointer wrap
    bus.in_valid = 1'b1; bus.in_cc = 4'h0;
    bus.in_result = 16'h00A0; tick();
    bus.in_result = 16'h00A1; tick();
    chk("pp_prefill_count", 16'(bus.count), 16'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_result = 16'h00A2 + 16'(i);
      chk("pp_head", bus.out_result, 16'h00A0 + 16'(i));
      tick();
      chk("pp_count", 16'(bus.count), 16'd2);
    end
    bus.in_valid = 1'b0;
    chk("pp_tail0", bus.out_result, 16'h00AA);
    tick();
    chk("pp_tail1", bus.out_result, 16'h00AB);
    tick();
    bus.out_ready = 1'b0;
    chk("pp_empty", 16'(bus.count), 16'd0);

    // sticky accumulation and clear/push overlap
    chk("stk_initial", 16'(bus.sticky), 16'h0);
    bus.in_valid = 1'b1; bus.in_result = 16'h7E00; bus.in_cc = 4'b0001;
    tick();
    exp_stk = STK ? 6'b100001 : 6'b000000;
    chk("stk_nan", 16'(bus.sticky), 16'(exp_stk));
    bus.in_result = 16'h7C00; bus.in_cc = 4'b0000;
    tick();
    exp_stk = STK ? 6'b110001 : 6'b000000;
    chk("stk_inf", 16'(bus.sticky), 16'(exp_stk));
    bus.in_result = 16'h0001; bus.in_cc = 4'b1000; bus.clear_sticky = 1'b1;
    tick();
    exp_stk = STK ? 6'b001000 : 6'b000000;
    chk("stk_clear_push", 16'(bus.sticky), 16'(exp_stk));
    bus.in_valid = 1'b0;
    tick();
    bus.clear_sticky = 1'b0;
    chk("stk_clear_only", 16'(bus.sticky), 16'h0);
    chk("stk_count", 16'(bus.count), 16'd3);
    bus.out_ready = 1'b1;
    chk("stk_q0_res", bus.out_result, 16'h7E00);
    chk("stk_q0_cc", 16'(bus.out_cc), 16'h1);
    tick();
    chk("stk_q1_res", bus.out_result, 16'h7C00);
    chk("stk_q1_cc", 16'(bus.out_cc), 16'h0);
    tick();
    chk("stk_q2_res", bus.out_result, 16'h0001);
    chk("stk_q2_cc", 16'(bus.out_cc), 16'h8);
    tick();
    bus.out_ready = 1'b0;
    chk("stk_no_pop_update", 16'(bus.sticky), 16'h0);

    // reset with three entries held and a push pending
    bus.in_valid = 1'b1; bus.in_cc = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      bus.in_result = 16'h0100 + 16'(i);
      tick();
    end
    chk("prerst_count", 16'(bus.count), 16'd3);
    exp_stk = STK ? 6'b000110 : 6'b000000;
    chk("prerst_sticky", 16'(bus.sticky), 16'(exp_stk));
    reset_L = 1'b0; bus.in_result = 16'h7C00; bus.clear_sticky = 1'b0;
    tick();
    reset_L = 1'b1; bus.in_valid = 1'b0;
    chk("midrst_count", 16'(bus.count), 16'd0);
    chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrst_sticky", 16'(bus.sticky), 16'h0);
    chk("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("midrst_out_result", bus.out_result, 16'h0);
    tick();
    chk("postrst_count", 16'(bus.count), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_result_queue16.md
FPU_RESULT_QUEUE16 -- requirements
Module: fpu_result_queue16

Interface
REQ-001 SHALL have parameter: DEPTH, 4, queue entries; power of two, 2..16.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_L  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  fpuAddSub16 result and condition codes valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  queue accepts a result this cycle.
REQ-006 SHALL have port: in_result  input  16  fp16_t result from fpuAddSub16.
REQ-007 SHALL have port: in_cc  input  4  condCode_t {Z,C,N,V} from fpuAddSub16.
REQ-008 SHALL have port: out_valid  output  1  head entry present.
REQ-009 SHALL have port: out_ready  input  1  consumer takes head entry.
REQ-010 SHALL have port: out_result  output  16  head result.
REQ-011 SHALL have port: out_cc  output  4  head condition codes.
REQ-012 SHALL have port: count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port: clear_sticky  input  1  clear sticky flags.
REQ-014 SHALL have port: sticky  output  6  {NAN,INF,Z,C,N,V} accumulated flags.

Function
REQ-015 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count != DEPTH); when full, a push attempt is ignored even if a pop occurs that cycle.
REQ-017 SHALL drive out_valid = (count != 0); out_result/out_cc SHALL show the head entry combinationally (first-word fall-through), and SHALL be 0 when empty.
REQ-018 SHALL have push-to-out_valid latency of exactly 1 cycle; an entry pushed into an empty queue is not visible in the same cycle.
REQ-019 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-020 SHALL wrap read and write pointers modulo DEPTH without losing or duplicating entries.
REQ-021 SHALL hold out_result/out_cc stable while out_valid && !out_ready.
REQ-022 SHALL update sticky as: next = (clear_sticky ? 0 : sticky) | (push ? flags(in) : 0); a push coinciding with a clear SHALL survive.
REQ-023 SHALL compute flags(in): NAN = exp==5'h1F && frac!=0; INF = exp==5'h1F && frac==0; Z,C,N,V copied from in_cc.
REQ-024 SHALL never update count or sticky from a pop.

Reset
REQ-025 SHALL, with reset_L low at a rising edge, set count=0, pointers=0, sticky=0, so out_valid=0, in_ready=1, out_result=0, out_cc=0 next cycle.
REQ-026 SHALL discard all entries on reset mid-operation; pushes/pops and clear_sticky in the reset cycle are ignored.
REQ-027 SHALL NOT require storage contents to be reset; only pointers, count and sticky.

Configuration
REQ-028 SHALL use macro FPU_RESULT_STICKY_EN to compile sticky-flag logic in.
REQ-029 SHALL, with FPU_RESULT_STICKY_EN defined, implement REQ-022/REQ-023.
REQ-030 SHALL, without FPU_RESULT_STICKY_EN, tie sticky to 0, ignore clear_sticky, and leave all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, push 16'h3C00 cc 4'b0000, out_ready=0 -> next cycle out_valid=1, out_result=16'h3C00, count=1, held stable 3 cycles.
REQ-032 SHALL cover: DEPTH=4, push 5 consecutive results 1..5 with out_ready=0 -> in_ready=0 after 4th, 5th dropped, count=4; then drain -> outputs 1,2,3,4 in order.
REQ-033 SHALL cover: count=2, simultaneous push and pop for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-034 SHALL cover (STICKY_EN): push 16'h7E00 cc 4'b0001, then 16'h7C00 -> sticky=6'b110001; clear_sticky with push of cc 4'b1000 same cycle -> sticky=6'b001000.
REQ-035 SHALL cover: queue holding 3 entries, reset_L=0 one cycle with in_valid=1 -> count=0, out_valid=0, sticky=0, no entry accepted.
REQ-036 SHALL cover (no STICKY_EN): REQ-034 stimulus -> sticky=0 throughout, queue data identical.
